// File: rtl/uart_tx_fifo_ctrl_if.sv
// Byte-feeder bundle between the upstream writer, the TX FIFO controller and the
// UART byte transmitter.
interface uart_tx_fifo_ctrl_if #(
  parameter int AW = 4
);
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          tx_done;
  logic [7:0]    data;
  logic          send_go;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          busy;
  logic          overflow;

  modport master (
    output wr_en, wr_data, tx_done,
    input  data, send_go, full, empty, count, busy, overflow
  );

  modport slave (
    input  wr_en, wr_data, tx_done,
    output data, send_go, full, empty, count, busy, overflow
  );
endinterface

// File: rtl/uart_tx_fifo_ctrl.sv
// Byte FIFO in front of the UART transmitter: pops one byte per Send_Go pulse
// and holds off the next pop until the transmitter reports Tx_done.
module uart_tx_fifo_ctrl #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  uart_tx_fifo_ctrl_if.slave   bus
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t        r_state;
  state_t        w_next_state;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_data;
  logic          r_send_go;
  logic          r_busy;
  logic          r_overflow;

  logic          w_full;
  logic          w_empty;
  logic          w_wr_accept;
  logic          w_pop;
  logic          w_done;

  // Full/Empty reflect the stored count before any pop in the same cycle.
  assign w_full      = (r_count == (AW+1)'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_wr_accept = bus.wr_en && !w_full;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        // A done pulse coinciding with our own Send_Go cannot belong to this byte.
        if (bus.tx_done && !r_send_go) begin
          w_done       = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: storage has no reset so it can map onto plain RAM; count/pointers define validity.
  always_ff @(posedge i_clk) begin
    if (w_wr_accept) r_mem[r_wr_ptr] <= bus.wr_data;
  end

  // NOTE: all state below is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data     <= 8'h00;
      r_send_go  <= 1'b0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_send_go <= w_pop;
      if (w_wr_accept) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (bus.wr_en && w_full) r_overflow <= 1'b1;
      if (w_pop) begin
        r_data   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_busy   <= 1'b1;
      end else if (w_done) begin
        r_busy   <= 1'b0;
      end
      case ({w_wr_accept, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.data     = r_data;
  assign bus.send_go  = r_send_go;
  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.count    = r_count;
  assign bus.busy     = r_busy;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed bench for uart_tx_fifo_ctrl: reset, single byte, burst, back-to-back,
// simultaneous write/pop, full/overflow, pointer wrap and mid-operation reset.
module tb_uart_tx_fifo_ctrl;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_fifo_ctrl_if #(.AW(AW)) bus ();

  uart_tx_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] rx_q [$];

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.tx_done = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic write_byte(input logic [7:0] value);
    bus.wr_en   = 1'b1;
    bus.wr_data = value;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  // Transmitter model: waits for each Send_Go, records Data, answers Tx_done after gap cycles.
  task automatic collect(input int n, input int gap, input string tag);
    for (int b = 0; b < n; b++) begin
      int cyc;
      cyc = 0;
      while (bus.send_go !== 1'b1 && cyc < 300) begin
        tick();
        cyc++;
      end
      checks++;
      if (bus.send_go !== 1'b1) begin
        errors++;
        $display("FAIL %s_timeout: byte %0d send_go=%b after %0d cycles, want 1", tag, b, bus.send_go, cyc);
        return;
      end
      rx_q.push_back(bus.data);
      tick();
      checks++;
      if (bus.send_go !== 1'b0) begin
        errors++;
        $display("FAIL %s_pulse: byte %0d send_go=%b one cycle later, want 0", tag, b, bus.send_go);
      end
      repeat (gap) tick();
      checks++;
      if (bus.data !== rx_q[$]) begin
        errors++;
        $display("FAIL %s_hold: byte %0d data=%h, want %h", tag, b, bus.data, rx_q[$]);
      end
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.tx_done = 1'b0;
    rst = 1'b1;
    tick();
    checks++; if (bus.count !== 5'd0)    begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    checks++; if (bus.empty !== 1'b1)    begin errors++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
    checks++; if (bus.full !== 1'b0)     begin errors++; $display("FAIL reset_full: got %b want 0", bus.full); end
    checks++; if (bus.data !== 8'h00)    begin errors++; $display("FAIL reset_data: got %h want 00", bus.data); end
    checks++; if (bus.send_go !== 1'b0)  begin errors++; $display("FAIL reset_send_go: got %b want 0", bus.send_go); end
    checks++; if (bus.busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_byte();
    apply_reset();
    write_byte(8'hA5);
    checks++; if (bus.send_go !== 1'b0) begin errors++; $display("FAIL single_go_early: got %b want 0", bus.send_go); end
    checks++; if (bus.count !== 5'd1)   begin errors++; $display("FAIL single_count_written: got %0d want 1", bus.count); end
    tick();
    checks++; if (bus.send_go !== 1'b1) begin errors++; $display("FAIL single_go: got %b want 1", bus.send_go); end
    checks++; if (bus.data !== 8'hA5)   begin errors++; $display("FAIL single_data: got %h want a5", bus.data); end
    checks++; if (bus.busy !== 1'b1)    begin errors++; $display("FAIL single_busy: got %b want 1", bus.busy); end
    checks++; if (bus.count !== 5'd0)   begin errors++; $display("FAIL single_count_popped: got %0d want 0", bus.count); end
    // Tx_done during the Send_Go cycle must be ignored.
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    checks++; if (bus.send_go !== 1'b0) begin errors++; $display("FAIL single_go_width: got %b want 0", bus.send_go); end
    checks++; if (bus.busy !== 1'b1)    begin errors++; $display("FAIL single_done_in_go: busy=%b want 1", bus.busy); end
    repeat (3) tick();
    checks++; if (bus.busy !== 1'b1)    begin errors++; $display("FAIL single_wait_hold: busy=%b want 1", bus.busy); end
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    checks++; if (bus.busy !== 1'b0)    begin errors++; $display("FAIL single_done_busy: got %b want 0", bus.busy); end
    checks++; if (bus.empty !== 1'b1)   begin errors++; $display("FAIL single_done_empty: got %b want 1", bus.empty); end
    checks++; if (bus.count !== 5'd0)   begin errors++; $display("FAIL single_done_count: got %0d want 0", bus.count); end
    // Tx_done in IDLE has no effect.
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    tick();
    checks++; if (bus.send_go !== 1'b0 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL idle_done: send_go=%b busy=%b want 0 0", bus.send_go, bus.busy); end
  endtask

  task automatic test_burst();
    int extra;
    apply_reset();
    rx_q.delete();
    fork
      begin
        for (int i = 1; i <= 5; i++) write_byte(8'(i));
      end
      collect(5, 9, "burst");
    join
    checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL burst_len: got %0d want 5", rx_q.size()); end
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== 8'(i + 1)) begin errors++; $display("FAIL burst_order[%0d]: got %h want %h", i, rx_q[i], 8'(i + 1)); end
    end
    extra = 0;
    repeat (20) begin
      tick();
      if (bus.send_go === 1'b1) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL burst_extra_go: got %0d pulses want 0", extra); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    write_byte(8'h31);
    write_byte(8'h32);
    write_byte(8'h33);
    repeat (2) tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    checks++; if (bus.send_go !== 1'b0 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL b2b_accept: send_go=%b busy=%b want 0 0", bus.send_go, bus.busy); end
    checks++; if (bus.count !== 5'd2) begin errors++; $display("FAIL b2b_count_before: got %0d want 2", bus.count); end
    tick();
    checks++; if (bus.send_go !== 1'b1) begin errors++; $display("FAIL b2b_go: got %b want 1", bus.send_go); end
    checks++; if (bus.data !== 8'h32)   begin errors++; $display("FAIL b2b_data: got %h want 32", bus.data); end
    checks++; if (bus.count !== 5'd1)   begin errors++; $display("FAIL b2b_count_after: got %0d want 1", bus.count); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    for (int i = 0; i < 4; i++) write_byte(8'h41 + 8'(i));
    tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    checks++; if (bus.count !== 5'd3 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL simul_idle: count=%0d busy=%b want 3 0", bus.count, bus.busy); end
    write_byte(8'h45);
    checks++; if (bus.count !== 5'd3)   begin errors++; $display("FAIL simul_count: got %0d want 3", bus.count); end
    checks++; if (bus.send_go !== 1'b1) begin errors++; $display("FAIL simul_go: got %b want 1", bus.send_go); end
    checks++; if (bus.data !== 8'h42)   begin errors++; $display("FAIL simul_data: got %h want 42", bus.data); end
  endtask

  task automatic test_full_overflow();
    apply_reset();
    for (int i = 1; i <= 17; i++) write_byte(8'(i));
    checks++; if (bus.count !== 5'd16)   begin errors++; $display("FAIL full_count: got %0d want 16", bus.count); end
    checks++; if (bus.full !== 1'b1)     begin errors++; $display("FAIL full_flag: got %b want 1", bus.full); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL full_ovf_early: got %b want 0", bus.overflow); end
    checks++; if (bus.data !== 8'h01 || bus.busy !== 1'b1)
      begin errors++; $display("FAIL full_inflight: data=%h busy=%b want 01 1", bus.data, bus.busy); end
    write_byte(8'd18);
    checks++; if (bus.count !== 5'd16)   begin errors++; $display("FAIL ovf_count: got %0d want 16", bus.count); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", bus.overflow); end
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    rx_q.delete();
    collect(16, 2, "drain");
    for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== 8'(i + 2)) begin errors++; $display("FAIL drain_order[%0d]: got %h want %h", i, rx_q[i], 8'(i + 2)); end
    end
    tick();
    checks++; if (bus.empty !== 1'b1 || bus.count !== 5'd0)
      begin errors++; $display("FAIL drain_empty: empty=%b count=%0d want 1 0", bus.empty, bus.count); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow); end
  endtask

  task automatic test_wrap();
    apply_reset();
    rx_q.delete();
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          write_byte(8'(i));
          repeat (3) tick();
        end
      end
      collect(40, 1, "wrap");
    join
    checks++; if (rx_q.size() != 40) begin errors++; $display("FAIL wrap_len: got %0d want 40", rx_q.size()); end
    for (int i = 0; i < 40 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== 8'(i)) begin errors++; $display("FAIL wrap_order[%0d]: got %h want %h", i, rx_q[i], 8'(i)); end
    end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL wrap_ovf: got %b want 0", bus.overflow); end
  endtask

  task automatic test_reset_mid();
    int extra;
    apply_reset();
    for (int i = 0; i < 6; i++) write_byte(8'h60 + 8'(i));
    checks++; if (bus.count !== 5'd5 || bus.busy !== 1'b1)
      begin errors++; $display("FAIL mid_setup: count=%0d busy=%b want 5 1", bus.count, bus.busy); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0)
      begin errors++; $display("FAIL mid_fifo: count=%0d empty=%b full=%b want 0 1 0", bus.count, bus.empty, bus.full); end
    checks++; if (bus.data !== 8'h00 || bus.send_go !== 1'b0 || bus.busy !== 1'b0 || bus.overflow !== 1'b0)
      begin errors++; $display("FAIL mid_outputs: data=%h go=%b busy=%b ovf=%b want 00 0 0 0",
                               bus.data, bus.send_go, bus.busy, bus.overflow); end
    repeat (2) tick();
    rst = 1'b0;
    extra = 0;
    repeat (10) begin
      tick();
      if (bus.send_go === 1'b1) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL mid_no_go: got %0d pulses want 0", extra); end
    write_byte(8'h77);
    checks++; if (bus.send_go !== 1'b0) begin errors++; $display("FAIL mid_go_early: got %b want 0", bus.send_go); end
    tick();
    checks++; if (bus.send_go !== 1'b1 || bus.data !== 8'h77)
      begin errors++; $display("FAIL mid_restart: go=%b data=%h want 1 77", bus.send_go, bus.data); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_back_to_back();
    test_simultaneous();
    test_full_overflow();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_fifo_ctrl.md
UART_TX_FIFO_CTRL -- requirements
Module: uart_tx_fifo_ctrl

Upstream feeder for the UART byte transmitter. It buffers bytes in a FIFO and issues one Send_Go per byte. It waits for Tx_done before issuing the next byte.

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in bytes (power of two, 2..256).
REQ-002 Parameter AW, default 4, pointer width, log2(DEPTH).
REQ-003 Clk  in  1  single clock; all logic rising-edge.
REQ-004 Reset  in  1  asynchronous, active-high reset.
REQ-005 Wr_en  in  1  write strobe, one byte per cycle high.
REQ-006 Wr_data  in  8  byte to enqueue.
REQ-007 Tx_done  in  1  one-cycle done pulse from the byte transmitter.
REQ-008 Data  out  8  byte presented to the transmitter (registered).
REQ-009 Send_Go  out  1  one-cycle start pulse to the transmitter (registered).
REQ-010 Full  out  1  FIFO holds DEPTH bytes.
REQ-011 Empty  out  1  FIFO holds 0 bytes.
REQ-012 Count  out  AW+1  bytes currently stored, excluding the byte in flight.
REQ-013 Busy  out  1  high from pop until Tx_done is accepted.
REQ-014 Overflow  out  1  sticky; set by a write while Full.

Function
REQ-015 Storage: DEPTH x 8 memory, write pointer and read pointer of AW bits each, both wrapping modulo DEPTH.
REQ-016 Write: Wr_en=1 and Full=0 stores Wr_data at the write pointer and increments it.
REQ-017 Write while Full=1: data dropped, pointers unchanged, Overflow set to 1 until reset.
REQ-018 Full and Empty are derived from Count at the current state, before the same-cycle pop is applied.
  - Consequence: a write in the same cycle as a pop with Full=1 is still dropped.
REQ-019 Count update per cycle: +1 on accepted write, -1 on pop, unchanged when both or neither occur. Count never exceeds DEPTH and never goes below 0.
REQ-020 FSM has two states, IDLE and WAIT.
REQ-021 In IDLE with Empty=0, one clock edge performs all of the following:
  - Data <= memory at the read pointer;
  - read pointer increments;
  - Send_Go <= 1;
  - Busy <= 1;
  - state -> WAIT.
REQ-022 Send_Go is high for exactly one cycle per popped byte.
REQ-023 Data is held stable from the Send_Go cycle until the next pop.
REQ-024 In WAIT, Tx_done=1 (excluding the Send_Go cycle itself) sets Busy <= 0 and state -> IDLE. Tx_done during the Send_Go cycle is ignored.
REQ-025 Tx_done in IDLE is ignored.
REQ-026 WAIT has no timeout; the block stays in WAIT until Tx_done arrives.
REQ-027 Latency, first byte into an empty idle FIFO:
  - Wr_en sampled at edge N;
  - pop at edge N+1;
  - Send_Go high during the cycle after edge N+1.
REQ-028 Back-to-back: with the FIFO non-empty, Send_Go for the next byte is high during the cycle after the edge following the accepted Tx_done.
REQ-029 Bytes are transmitted in write order with no loss or duplication, except bytes dropped under REQ-017.

Reset
REQ-030 Reset=1 asynchronously forces the following, regardless of state or in-flight byte:
  - pointers=0, Count=0, Empty=1, Full=0;
  - Data=8'h00, Send_Go=0, Busy=0, Overflow=0;
  - state=IDLE.
REQ-031 Memory contents need no reset.
REQ-032 After Reset deasserts, the first pop occurs no earlier than one cycle after the first accepted write.

Verification
REQ-033 Single byte: reset, write 8'hA5 at edge N -> Send_Go one cycle after edge N+1, Data=8'hA5, Busy=1; Tx_done pulse -> Busy=0, Empty=1, Count=0.
REQ-034 Burst: write 8'h01..8'h05 on consecutive cycles, Tx_done 10 cycles after each Send_Go -> exactly 5 Send_Go pulses with Data 01,02,03,04,05 in order.
REQ-035 Full/overflow: DEPTH=16, hold Tx_done=0, write 18 bytes.
  - One byte is popped to the transmitter, so 16 are stored: Count=16, Full=1.
  - 18th write is dropped; Overflow=1 and stays 1 after the FIFO drains.
REQ-036 Simultaneous write and pop: Count=3 in IDLE, write on the pop edge -> Count stays 3.
REQ-037 Pointer wrap: DEPTH=16, stream 40 bytes with incrementing values while keeping Count<16 -> all 40 transmitted in order.
REQ-038 Reset mid-operation: assert Reset while in WAIT with Count=5 -> all outputs at REQ-030 values immediately; no Send_Go after release until a new write.
